// File: rtl/keypad_pkg.sv
// Shared constants and the KEYCNT register layout for the keypad register block.
package keypad_pkg;

  localparam int NUM_KEYS = 10;

  localparam int KEY_A      = 0;
  localparam int KEY_B      = 1;
  localparam int KEY_SELECT = 2;
  localparam int KEY_START  = 3;
  localparam int KEY_RIGHT  = 4;
  localparam int KEY_LEFT   = 5;
  localparam int KEY_UP     = 6;
  localparam int KEY_DOWN   = 7;
  localparam int KEY_R      = 8;
  localparam int KEY_L      = 9;

  localparam logic ADDR_KEYINPUT = 1'b0;
  localparam logic ADDR_KEYCNT   = 1'b1;

  localparam int KEYCNT_IRQ_EN_BIT = 14;
  localparam int KEYCNT_AND_BIT    = 15;

  localparam logic [15:0] KEYINPUT_RST = 16'h03FF;

  typedef struct packed {
    logic                cond_and;
    logic                irq_en;
    logic [NUM_KEYS-1:0] mask;
  } keycnt_t;

  // Bits 13:10 have no storage and always read back as zero.
  function automatic logic [15:0] keycnt_pack(input keycnt_t k);
    logic [15:0] v;
    v = '0;
    v[NUM_KEYS-1:0]      = k.mask;
    v[KEYCNT_IRQ_EN_BIT] = k.irq_en;
    v[KEYCNT_AND_BIT]    = k.cond_and;
    return v;
  endfunction

endpackage

// File: rtl/keypad_regs_key_debounce.sv
// Single-key debouncer: the stable level follows raw only after raw has
// differed from it for DEBOUNCE consecutive cycles.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      stable <= raw;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_regs.sv
// GBA keypad block: debounced KEYINPUT, KEYCNT control register on the
// halfword I/O bus, and a single-cycle keypad interrupt request.
module keypad_regs
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_n,
  input  logic                sel,
  input  logic                we,
  input  logic                addr,
  input  logic [1:0]          be,
  input  logic [15:0]         wdata,
  output logic [15:0]         rdata,
  output logic                rvalid,
  output logic                irq
);

  logic [NUM_KEYS-1:0] raw_q;
  logic [NUM_KEYS-1:0] stable;
  keycnt_t             keycnt;
  logic [15:0]         keyinput;
  logic [15:0]         rd_val;
  logic [NUM_KEYS-1:0] hits;
  logic                or_hit;
  logic                and_hit;
  logic                cond;
  logic                cond_q;
  logic                unused_wdata;

  assign unused_wdata = ^wdata[13:10];

  always_ff @(posedge clk) begin
    if (rst) raw_q <= '1;
    else     raw_q <= keys_n;
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_q[gi]),
      .stable(stable[gi])
    );
  end

  assign keyinput = {6'b0, stable};

  // Bus: an access is one cycle with sel high. Writes complete at that edge
  // with no response; reads return rdata with a one-cycle rvalid pulse on the
  // following cycle, and may be issued back to back every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      keycnt <= '0;
    end else if (sel && we && (addr == ADDR_KEYCNT)) begin
      if (be[0]) keycnt.mask[7:0] <= wdata[7:0];
      if (be[1]) begin
        keycnt.mask[9:8] <= wdata[9:8];
        keycnt.irq_en    <= wdata[KEYCNT_IRQ_EN_BIT];
        keycnt.cond_and  <= wdata[KEYCNT_AND_BIT];
      end
    end
  end

  assign rd_val = (addr == ADDR_KEYCNT) ? keycnt_pack(keycnt) : keyinput;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= sel && !we;
      if (sel && !we) rdata <= rd_val;
    end
  end

  // Condition is built from registered state only, so a write and a key
  // change landing on the same edge are both seen together.
  always_comb begin
    hits    = keycnt.mask & ~stable;
    or_hit  = |hits;
    and_hit = (keycnt.mask != '0) && (hits == keycnt.mask);
    cond    = keycnt.irq_en && (keycnt.cond_and ? and_hit : or_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      cond_q <= cond;
      irq    <= cond && !cond_q;
    end
  end

endmodule

// File: tb/tb_keypad_regs.sv
// Directed self-checking bench for keypad_regs: read scoreboard, debounce
// latency, OR/AND interrupt modes, byte enables and reset behaviour.
module tb_keypad_regs;

  localparam int DEBOUNCE = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  keys_n;
  logic        sel;
  logic        we;
  logic        addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        irq;

  keypad_regs #(.DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .rst   (rst),
    .keys_n(keys_n),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid),
    .irq   (irq)
  );

  int          tests = 0;
  int          fails = 0;
  int          irq_cnt = 0;
  int          base;
  logic [15:0] exp_q[$];
  logic [15:0] m_keycnt;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance across one rising edge; observe outputs on the falling edge.
  task automatic step();
    @(negedge clk);
    if (irq === 1'b1) irq_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // driver tasks
  task automatic do_read(input logic a, input logic [15:0] exp, input string tag);
    sel = 1'b1; we = 1'b0; addr = a; be = 2'b00;
    exp_q.push_back(exp);
    step();
    sel = 1'b0;
    check({tag, " rvalid"}, {15'd0, rvalid}, 16'd1);
    check(tag, rdata, exp_q.pop_front());
  endtask

  task automatic do_write(input logic a, input logic [1:0] b, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
    step();
    sel = 1'b0; we = 1'b0; be = 2'b00;
    if (a) begin
      if (b[0]) m_keycnt[7:0] = d[7:0];
      if (b[1]) begin
        m_keycnt[9:8]   = d[9:8];
        m_keycnt[15:14] = d[15:14];
      end
    end
  endtask

  // Back-to-back KEYINPUT reads right after a raw change: the read sampled at
  // edge k shows the new level once k >= DEBOUNCE+2.
  task automatic read_latency(input logic [15:0] old_v, input logic [15:0] new_v, input string tag);
    for (int k = 1; k <= DEBOUNCE + 3; k++)
      do_read(1'b0, (k >= DEBOUNCE + 2) ? new_v : old_v, tag);
  endtask

  task automatic irq_timing(input string tag);
    for (int k = 1; k <= DEBOUNCE + 1; k++) begin
      step();
      check({tag, " early"}, {15'd0, irq}, 16'd0);
    end
    step();
    check({tag, " pulse"}, {15'd0, irq}, 16'd1);
    step();
    check({tag, " single"}, {15'd0, irq}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; keys_n = '1; sel = 1'b0; we = 1'b0; addr = 1'b0;
    be = 2'b00; wdata = '0; m_keycnt = '0;
    steps(2);
    check("rst rdata", rdata, 16'h0000);
    check("rst rvalid", {15'd0, rvalid}, 16'd0);
    check("rst irq", {15'd0, irq}, 16'd0);
    rst = 1'b0;

    do_read(1'b0, 16'h03FF, "rd keyinput rst");
    step();
    check("rvalid drop", {15'd0, rvalid}, 16'd0);
    check("rdata hold", rdata, 16'h03FF);
    do_read(1'b1, 16'h0000, "rd keycnt rst");

    // Press A, measure visibility latency
    keys_n[0] = 1'b0;
    read_latency(16'h03FF, 16'h03FE, "press A");

    // 3-cycle glitch on B must never reach KEYINPUT
    keys_n[1] = 1'b0;
    steps(3);
    keys_n[1] = 1'b1;
    for (int k = 0; k < 8; k++) do_read(1'b0, 16'h03FE, "glitch B");

    keys_n[0] = 1'b1;
    steps(8);
    do_read(1'b0, 16'h03FF, "release A");
    check("no irq yet", 16'(irq_cnt), 16'd0);

    // OR mode on A|B
    do_write(1'b1, 2'b11, 16'h4003);
    steps(3);
    base = irq_cnt;
    check("or idle", 16'(irq_cnt), 16'(base));
    keys_n[1] = 1'b0;
    irq_timing("or press B");
    steps(50);
    check("or hold", 16'(irq_cnt), 16'(base + 1));
    keys_n[1] = 1'b1;
    steps(10);
    keys_n[1] = 1'b0;
    steps(10);
    check("or repress", 16'(irq_cnt), 16'(base + 2));
    keys_n[1] = 1'b1;
    steps(10);

    // AND mode on Select+Start
    do_write(1'b1, 2'b11, 16'hC00C);
    base = irq_cnt;
    keys_n[2] = 1'b0;
    steps(10);
    check("and partial", 16'(irq_cnt), 16'(base));
    keys_n[3] = 1'b0;
    irq_timing("and both");
    steps(3);
    do_write(1'b1, 2'b11, 16'hC000);
    steps(10);
    check("and zero mask", 16'(irq_cnt), 16'(base + 1));
    do_read(1'b1, m_keycnt, "rd keycnt C000");
    keys_n[3:2] = 2'b11;
    steps(10);

    // Enable irq_en with the condition already met via upper byte only
    keys_n[0] = 1'b0;
    steps(8);
    do_write(1'b1, 2'b11, 16'h0001);
    steps(3);
    base = irq_cnt;
    check("en off", 16'(irq_cnt), 16'(base));
    do_write(1'b1, 2'b10, 16'h4000);
    check("en write edge", {15'd0, irq}, 16'd0);
    step();
    check("en pulse", {15'd0, irq}, 16'd1);
    step();
    check("en single", {15'd0, irq}, 16'd0);
    do_read(1'b1, m_keycnt, "rd keycnt be10");

    do_write(1'b1, 2'b00, 16'hFFFF);
    do_read(1'b1, m_keycnt, "rd keycnt be00");
    do_write(1'b0, 2'b11, 16'h0000);
    do_read(1'b0, 16'h03FE, "keyinput ro");
    do_write(1'b1, 2'b11, 16'hFFFF);
    do_read(1'b1, m_keycnt, "rd keycnt unstored");

    // Reset mid-debounce, with irq_en set and a read in flight
    do_write(1'b1, 2'b11, 16'h4002);
    base = irq_cnt;
    keys_n[1] = 1'b0;
    steps(2);
    rst = 1'b1; sel = 1'b1; we = 1'b0; addr = 1'b0;
    step();
    sel = 1'b0;
    check("mid rst rvalid", {15'd0, rvalid}, 16'd0);
    check("mid rst rdata", rdata, 16'h0000);
    check("mid rst irq", {15'd0, irq}, 16'd0);
    rst = 1'b0;
    m_keycnt = '0;
    read_latency(16'h03FF, 16'h03FC, "post rst");
    steps(20);
    check("post rst no irq", 16'(irq_cnt), 16'(base));
    do_read(1'b1, m_keycnt, "post rst keycnt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_regs.md
Name: keypad_regs

Overview:
- Sits directly downstream of the PS/2 scan-code decoder, which delivers a 10-bit active-low button vector: bit 0 A, 1 B, 2 Select, 3 Start, 4 Right, 5 Left, 6 Up, 7 Down, 8 R, 9 L.
- Debounces each button and exposes the GBA KEYINPUT register (0x04000130) and KEYCNT register (0x04000132) on the I/O halfword bus.
- Generates the keypad interrupt request for the interrupt controller.

Parameters:
- DEBOUNCE, 4, consecutive cycles a raw key level must differ from the stable level before it is accepted; legal range 1..65535.
- CW, $clog2(DEBOUNCE+1), width of each per-key debounce counter (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- keys_n  in  10  raw button vector, active-low (0 = pressed); synchronous to clk
- sel  in  1  bus access strobe, one cycle per access
- we  in  1  1 = write, 0 = read; qualified by sel
- addr  in  1  0 = KEYINPUT, 1 = KEYCNT
- be  in  2  byte enables; be[0] covers bits 7:0, be[1] covers bits 15:8
- wdata  in  16  write data
- rdata  out  16  read data, registered
- rvalid  out  1  one-cycle pulse, read data valid
- irq  out  1  one-cycle keypad interrupt request pulse

Behaviour:
- Reset values (rst high at a clk edge):
  - raw_q = 0x3FF and stable = 0x3FF (all keys released); all counters = 0.
  - KEYCNT = 0x0000; rdata = 0; rvalid = 0; irq = 0; cond_q = 0.
- Input stage: raw_q <= keys_n every cycle.
- Per-key debounce:
  - raw_q[i] == stable[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE-1, stable[i] <= raw_q[i] and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE cycles never reaches stable.
  - Latency: a clean keys_n change is visible in KEYINPUT DEBOUNCE+1 cycles later.
- KEYINPUT = {6'b0, stable}. Read-only; writes are ignored.
- KEYCNT holds:
  - mask[9:0] in bits 9:0.
  - irq_en in bit 14.
  - cond_and in bit 15 (0 = OR mode, 1 = AND mode).
  - Bits 13:10 are not stored and read as 0.
- KEYCNT write (sel & we & addr):
  - be[0] updates mask[7:0].
  - be[1] updates mask[9:8], irq_en and cond_and.
  - be = 0 updates nothing.
  - The new value takes effect at the write edge.
- Read (sel & ~we):
  - At the edge, rdata <= selected register value and rvalid <= 1.
  - Next edge: rvalid <= 0 unless another read occurs; rdata holds its value.
  - Back-to-back reads are allowed, one per cycle.
  - be is ignored for reads.
- Interrupt condition, with pressed = ~stable:
  - OR mode: |(mask & pressed).
  - AND mode: (mask != 0) && ((mask & pressed) == mask). A zero mask never fires.
  - cond = irq_en & mode_result.
- cond_q <= cond every cycle. irq <= cond & ~cond_q, so irq is a single-cycle pulse on each rising edge of cond.
  - Holding the keys produces no further pulses.
  - Releasing and re-pressing produces a new pulse.
  - Key-to-irq latency: DEBOUNCE+2 cycles.
- Boundary cases:
  - Enabling irq_en while the condition is already met yields one pulse, one cycle after the write edge.
  - A write and a key change on the same edge: cond is evaluated from the registers as updated at that edge.
  - Reset mid-debounce discards partial counts.
  - Reset during a read cancels rvalid.

Decomposition:
- Shared package keypad_pkg:
  - KEY_A..KEY_L bit indices.
  - ADDR_KEYINPUT, ADDR_KEYCNT.
  - KEYCNT_IRQ_EN_BIT = 14, KEYCNT_AND_BIT = 15.
  - KEYINPUT_RST = 16'h03FF.
  - NUM_KEYS = 10.
- Sub-module key_debounce: one bit, parameter DEBOUNCE, ports clk, rst, raw, stable. Instantiated NUM_KEYS times in a generate loop.

Test Plan:
- Reset with DEBOUNCE=4, then read addr 0 -> rvalid one cycle later, rdata=0x03FF. Read addr 1 -> rdata=0x0000, irq stays 0.
- Drive keys_n[0]=0 at cycle t and hold it -> KEYINPUT reads 0x03FE from cycle t+5. A 3-cycle low glitch on keys_n[1] -> KEYINPUT never leaves 0x03FE.
- Write KEYCNT=0x4003, be=11 (OR mode, A|B). Press B -> exactly one irq pulse 6 cycles after the keys_n change. Hold B 50 cycles -> no further pulse. Release and re-press -> second pulse.
- Write KEYCNT=0xC00C (AND, Select+Start). Press Select only -> no irq. Add Start -> one pulse. Write KEYCNT=0xC000 -> irq stays 0.
- Hold A pressed with KEYCNT=0x0001, then write be=10 with wdata=0x4000 -> mask stays 0x001, irq_en set, one irq pulse the cycle after the write. Read KEYCNT -> 0x4001.
- Assert rst during a key debounce and with irq_en set -> all outputs return to reset values the next cycle, KEYINPUT=0x03FF, no spurious irq after rst is released.
